// File: rtl/dcache_wb_ctrl.sv
// dcache_wb_ctrl: drains dcache write-FIFO lines as 4-beat INCR bursts and merges uncached stores onto one AXI write port.
// Define DCACHE_WB_ERR_EN to enable the sticky wb_err_o bus-error flag.
module dcache_wb_ctrl #(
  parameter int LINE_WIDTH = 128,
  parameter int AXI_DW = 32,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            fifo_state_i,
  input  logic                  fifo_wen_i,
  input  logic [31:0]           fifo_addr_i,
  input  logic [LINE_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_free_o,
  input  logic                  uc_req_i,
  input  logic [31:0]           uc_addr_i,
  input  logic [AXI_DW-1:0]     uc_data_i,
  input  logic [AXI_DW/8-1:0]   uc_strb_i,
  output logic                  uc_ack_o,
  output logic                  uc_done_o,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_DW-1:0]     wdata,
  output logic [AXI_DW/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  wb_err_o
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;
  state_t state_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic [1:0] beat_q;
  logic uc_q, aw_done_q, w_done_q;
  logic take_uc, take_line, aw_hs, w_hs, last_hs;
  // A full FIFO must drain before any uncached store is taken.
  assign take_uc     = state_q == IDLE && !rst && uc_req_i && !fifo_state_i[1];
  assign fifo_free_o = state_q == IDLE && !rst && !take_uc;
  assign uc_ack_o    = take_uc;
  assign take_line   = fifo_free_o && fifo_wen_i;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign last_hs     = w_hs && wlast;
  assign wdata       = data_q[AXI_DW-1:0];
  assign uc_done_o   = state_q == WAIT_B && bvalid && uc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      beat_q    <= '0;
      uc_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awlen     <= '0;
      awsize    <= '0;
      awburst   <= '0;
      awvalid   <= 1'b0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take_uc || take_line) begin
          state_q   <= SEND;
          awvalid   <= 1'b1;
          wvalid    <= 1'b1;
          awid      <= AXI_ID;
          awsize    <= 3'($clog2(AXI_DW/8));
          awburst   <= 2'b01;
          awaddr    <= take_uc ? uc_addr_i : fifo_addr_i;
          awlen     <= take_uc ? 8'd0 : 8'(LINE_WIDTH/AXI_DW-1);
          wstrb     <= take_uc ? uc_strb_i : '1;
          data_q    <= take_uc ? LINE_WIDTH'(uc_data_i) : fifo_data_i;
          wlast     <= take_uc;
          uc_q      <= take_uc;
          beat_q    <= '0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        SEND: begin
          if (aw_hs) begin
            awvalid   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          // Shift the line down so the current beat always sits in the low word.
          if (w_hs) begin
            beat_q <= beat_q + 2'd1;
            data_q <= data_q >> AXI_DW;
            wlast  <= beat_q == 2'd2;
          end
          if (last_hs) begin
            wvalid   <= 1'b0;
            wlast    <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || last_hs)) begin
            state_q <= WAIT_B;
            bready  <= 1'b1;
          end
        end
        WAIT_B: if (bvalid) begin
          state_q <= IDLE;
          bready  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DCACHE_WB_ERR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) wb_err_o <= 1'b0;
    else if (state_q == WAIT_B && bvalid && (bresp != 2'b00 || bid != AXI_ID)) wb_err_o <= 1'b1;
  logic unused_empty;
  assign unused_empty = fifo_state_i[0];
`else
  assign wb_err_o = 1'b0;
  logic unused_b;
  assign unused_b = ^{fifo_state_i[0], bid, bresp};
`endif
endmodule
